parameterized_fifo_flags: RTL and testbench
===========================================

Name: parameterized_fifo_flags

Overview:
Synchronous FIFO with parametrised data width and depth, extending the single-bit parameterized_fifo. Adds full/empty and programmable almost-full/almost-empty flags, an occupancy count, and sticky overflow/underflow error flags. A mode parameter selects registered-read or first-word-fall-through output. It serves as the general buffering primitive between same-clock producers and consumers.

Parameters:
W, 8, data width in bits (>=1)
D, 4, depth in entries (>=2; need not be a power of two)
AF_LEVEL, D-1, almost_full asserts when count >= AF_LEVEL (1..D)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..D-1)
FWFT, 0, 0 = registered read (data one cycle after read_en); 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in  input  W  write data
write_en  input  1  write request, sampled on the rising edge
read_en  input  1  read/pop request, sampled on the rising edge
err_clr  input  1  synchronous clear of overflow/underflow
out  output  W  read data
full  output  1  count == D
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(D+1)  current occupancy, 0..D
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, out=0, overflow=underflow=0. Storage contents are not reset. Flags after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0)=0. Asserting reset mid-operation discards all contents immediately.
- Outputs full, empty, almost_full and almost_empty decode combinationally from the count register, so they update in the same cycle as count.
- Write accepted when write_en && (!full || read_accepted). The data is stored at mem[wr_ptr], and wr_ptr advances, wrapping D-1 -> 0.
- Read accepted when read_en && !empty. rd_ptr advances with the same wrap rule.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with write_en && read_en: both are accepted, count stays at D, and overflow is not set.
- Full with write_en && !read_en: the write is dropped, memory is unchanged, and overflow is set.
- Empty with read_en: the read is rejected and underflow is set. A simultaneous write is still accepted, giving count=1. The new data is not bypassed to the read.
- overflow/underflow stay set until err_clr=1 at a clock edge or until reset. If err_clr is high in the same cycle as a new error event, the error wins and the flag stays set.
- FWFT=0: on an accepted read, out <= mem[rd_ptr] at that edge, so it is valid the cycle after read_en. Otherwise out holds its last value, including on a rejected read.
- FWFT=1: out shows mem[rd_ptr] combinationally whenever !empty, and is 0 when empty. An accepted read pops the head, and the next entry appears after the edge.
- Ordering is strictly first-in first-out across pointer wrap. No data corruption is allowed when wr_ptr == rd_ptr, whether full or empty.

Test Plan:
1. W=8, D=4, FWFT=0. Reset, then write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full=1 at count 3; full=1 after the fourth write. Then 4 reads -> out 0x11,0x22,0x33,0x44, each one cycle after read_en; empty=1 at the end; no error flags.
2. When full, write 0x55 with read_en=0 -> overflow=1, count=4. Reads return 0x11..0x44 (0x55 absent). err_clr pulse -> overflow=0.
3. When empty, read_en=1 -> underflow=1 and out holds its previous value. Then read_en=1 and write_en=1 with in=0xA5 in the same cycle while empty -> count=1, and 0xA5 is read next.
4. When full, write_en=1 and read_en=1 with in=0x66 -> count stays 4, no overflow, out=head. Draining yields the remaining three entries then 0x66. Repeat 10 times to exercise pointer wrap.
5. FWFT=1: write 0x77 -> out=0x77 the cycle after the write with no read. read_en=1 -> empty=1 and out=0 after the edge.
6. Assert rst low asynchronously mid-clock with count=3 and overflow=1 -> immediately count=0, empty=1, out=0, overflow=0. After release, the first write/read pair returns the new data only.

Source files
------------

// File: rtl/parameterized_fifo_flags_if.sv
// Handshake/data bundle for parameterized_fifo_flags: the producer/consumer side is the master
// and the FIFO is the slave.
interface parameterized_fifo_flags_if #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 4
);
  localparam int unsigned CW = $clog2(D + 1);

  logic [W-1:0]  in;
  logic          write_en;
  logic          read_en;
  logic          err_clr;
  logic [W-1:0]  out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  modport master (
    output in, write_en, read_en, err_clr,
    input  out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  in, write_en, read_en, err_clr,
    output out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/parameterized_fifo_flags.sv
// Same-clock FIFO with occupancy count, full/empty/almost flags, sticky overflow/underflow and a
// choice of registered-read or first-word-fall-through output.
module parameterized_fifo_flags #(
  parameter int unsigned W        = 8,
  parameter int unsigned D        = 4,
  parameter int unsigned AF_LEVEL = D - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input logic                       clk,
  input logic                       rst,
  parameterized_fifo_flags_if.slave bus
);
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned PW = $clog2(D);

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;

  assign w_full  = (r_count == CW'(D));
  assign w_empty = (r_count == '0);

  // A pop frees the slot this same edge, so a write at full still fits.
  assign w_rd_acc = bus.read_en && !w_empty;
  assign w_wr_acc = bus.write_en && (!w_full || w_rd_acc);

  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(D - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(D - 1)) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new error event outranks a clear in the same cycle.
      r_overflow  <= (bus.write_en && !w_wr_acc) || (r_overflow && !bus.err_clr);
      r_underflow <= (bus.read_en && w_empty) || (r_underflow && !bus.err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.in;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.out = w_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_reg
    logic [W-1:0] r_out;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_out <= '0;
      end else if (w_rd_acc) begin
        r_out <= r_mem[r_rd_ptr];
      end
    end
    assign bus.out = r_out;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_parameterized_fifo_flags.sv
// Drives a registered-read and an FWFT instance with identical stimulus and checks both against
// a queue-based reference model.
module tb_parameterized_fifo_flags;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = D - 1;
  localparam int unsigned AE = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  parameterized_fifo_flags_if #(.W(W), .D(D)) f0 ();
  parameterized_fifo_flags_if #(.W(W), .D(D)) f1 ();

  parameterized_fifo_flags #(.W(W), .D(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (f0)
  );

  parameterized_fifo_flags #(.W(W), .D(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f1)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] m_out0;
  logic         m_ovf;
  logic         m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out0 = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Behaviour of one clock edge, stated directly in queue terms.
  task automatic model_step(input logic we, input logic re, input logic clr,
                            input logic [W-1:0] din);
    bit was_full, was_empty, rd, wr;
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    rd = re && !was_empty;
    wr = we && (!was_full || rd);
    if (rd) m_out0 = q.pop_front();
    if (wr) q.push_back(din);
    m_ovf = (we && !wr) || (m_ovf && !clr);
    m_udf = (re && was_empty) || (m_udf && !clr);
  endtask

  task automatic check_all();
    int n;
    logic [W-1:0] head;
    n = q.size();
    head = (n != 0) ? q[0] : '0;
    chk("count0", 32'(f0.count), n);
    chk("full0", 32'(f0.full), 32'(n == D));
    chk("empty0", 32'(f0.empty), 32'(n == 0));
    chk("afull0", 32'(f0.almost_full), 32'(n >= AF));
    chk("aempty0", 32'(f0.almost_empty), 32'(n <= AE));
    chk("ovf0", 32'(f0.overflow), 32'(m_ovf));
    chk("udf0", 32'(f0.underflow), 32'(m_udf));
    chk("out0", 32'(f0.out), 32'(m_out0));
    chk("count1", 32'(f1.count), n);
    chk("ovf1", 32'(f1.overflow), 32'(m_ovf));
    chk("udf1", 32'(f1.underflow), 32'(m_udf));
    chk("out1", 32'(f1.out), 32'(head));
  endtask

  task automatic drive(input logic we, input logic re, input logic clr, input logic [W-1:0] din);
    f0.write_en = we;  f1.write_en = we;
    f0.read_en  = re;  f1.read_en  = re;
    f0.err_clr  = clr; f1.err_clr  = clr;
    f0.in       = din; f1.in       = din;
  endtask

  task automatic cyc(input logic we, input logic re, input logic clr, input logic [W-1:0] din);
    drive(we, re, clr, din);
    @(posedge clk);
    model_step(we, re, clr, din);
    #1;
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    #12;
    check_all();
    chk("rst_empty", 32'(f0.empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1: fill then drain
    cyc(1'b1, 1'b0, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 1'b0, 8'h33);
    chk("t1_af3", 32'(f0.almost_full), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h44);
    chk("t1_full", 32'(f0.full), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t1_rd1", 32'(f0.out), 32'h11);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t1_rd4", 32'(f0.out), 32'h44);

    // 2: overflow when full, then clear
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)));
    cyc(1'b1, 1'b0, 1'b0, 8'h55);
    chk("t2_ovf", 32'(f0.overflow), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t2_last", 32'(f0.out), 32'h44);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t2_clr", 32'(f0.overflow), 32'd0);

    // 3: underflow, then write+read while empty
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t3_udf", 32'(f0.underflow), 32'd1);
    chk("t3_hold", 32'(f0.out), 32'h44);
    cyc(1'b1, 1'b1, 1'b0, 8'hA5);
    chk("t3_cnt", 32'(f0.count), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    chk("t3_a5", 32'(f0.out), 32'hA5);

    // 4: simultaneous read/write at full, repeated across pointer wrap
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(r * 16 + i));
      cyc(1'b1, 1'b1, 1'b0, 8'h66);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("t4_tail", 32'(f0.out), 32'h66);

    // 5: FWFT visibility
    cyc(1'b1, 1'b0, 1'b0, 8'h77);
    chk("t5_fwft", 32'(f1.out), 32'h77);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t5_zero", 32'(f1.out), 32'h00);

    // 6: asynchronous reset mid-cycle with count=3 and overflow set
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_pre", 32'(f0.count), 32'd3);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h3C);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6_new", 32'(f0.out), 32'h3C);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 8), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end
endmodule
